// File: rtl/mmio_uart_tx_if.sv
// Core data-memory port as seen by the UART transmitter register window.
interface mmio_uart_tx_if;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic        sel;
    logic [31:0] rdata;

    modport master (output memwrite, addr, writedata, input sel, rdata);
    modport slave  (input memwrite, addr, writedata, output sel, rdata);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/DIVISOR registers,
// a small TX FIFO and a start/data/stop serialiser driving txd.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_FF00,
    parameter int unsigned DEPTH     = 4,
    parameter logic [15:0] DIV_RESET = 16'd433
) (
    input  logic              clk,
    input  logic              reset,
    mmio_uart_tx_if.slave     bus,
    output logic              txd
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t             r_state, w_state_nxt;
    logic [15:0]        r_timer, w_timer_nxt;
    logic [2:0]         r_idx, w_idx_nxt, w_idx_inc;
    logic [7:0]         r_shift, w_shift_nxt;
    logic               r_txd, w_txd_nxt;
    logic [15:0]        r_div;
    logic               r_ovf;
    logic [7:0]         r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_sel, w_wr, w_push_req, w_push_ok, w_pop;
    logic               w_full, w_empty, w_busy, w_timer_zero, w_ovf_clr;
    logic [1:0]         w_off;
    logic [31:0]        w_rdata;
    logic               w_unused;

    // Address decode and register-write strobes
    assign w_sel      = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign w_off      = bus.addr[3:2];
    assign w_wr       = bus.memwrite & w_sel;
    assign w_push_req = w_wr & (w_off == 2'd0);
    assign w_push_ok  = w_push_req & ~w_full;
    assign w_ovf_clr  = w_wr & (w_off == 2'd1) & bus.writedata[3];
    assign w_unused   = ^{bus.addr[1:0], bus.writedata[31:16]};

    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_empty      = (r_count == CNT_W'(0));
    assign w_busy       = (r_state != S_IDLE);
    assign w_timer_zero = (r_timer == 16'd0);
    assign w_idx_inc    = r_idx + 3'd1;

    always_comb begin
        w_rdata = 32'd0;
        if (w_sel) begin
            case (w_off)
                2'd1:    w_rdata = {24'd0, 4'(r_count), r_ovf, w_empty, w_full, w_busy};
                2'd2:    w_rdata = {16'd0, r_div};
                default: w_rdata = 32'd0;
            endcase
        end
    end

    assign bus.sel   = w_sel;
    assign bus.rdata = w_rdata;
    assign txd       = r_txd;

    // Serialiser next-state: every bit lasts DIVISOR+1 cycles
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_txd_nxt   = r_txd;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_timer_nxt = r_div;
                    w_state_nxt = S_START;
                    w_txd_nxt   = 1'b0;
                end
            end
            S_START: begin
                if (w_timer_zero) begin
                    w_timer_nxt = r_div;
                    w_idx_nxt   = 3'd0;
                    w_state_nxt = S_DATA;
                    w_txd_nxt   = r_shift[0];
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
            S_DATA: begin
                if (w_timer_zero) begin
                    w_timer_nxt = r_div;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_txd_nxt   = 1'b1;
                    end else begin
                        w_idx_nxt = w_idx_inc;
                        w_txd_nxt = r_shift[w_idx_inc];
                    end
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
            S_STOP: begin
                if (w_timer_zero) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = r_mem[r_rd_ptr];
                        w_timer_nxt = r_div;
                        w_state_nxt = S_START;
                        w_txd_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_timer <= 16'd0;
            r_idx   <= 3'd0;
            r_shift <= 8'd0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

    // Register file and FIFO bookkeeping; full is judged on the pre-edge count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div    <= DIV_RESET;
            r_ovf    <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr && (w_off == 2'd2)) r_div <= bus.writedata[15:0];
            if (w_push_req && w_full)    r_ovf <= 1'b1;
            else if (w_ovf_clr)          r_ovf <= 1'b0;
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= bus.writedata[7:0];
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'h0000_FF00;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_ST = BASE + 32'h4;
    localparam logic [31:0] A_DV = BASE + 32'h8;

    logic clk = 1'b0;
    logic reset;
    logic txd;
    int   n_vec  = 0;
    int   n_miss = 0;

    mmio_uart_tx_if u_bus ();

    mmio_uart_tx u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_bus),
        .txd   (txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        u_bus.memwrite  = 1'b1;
        u_bus.addr      = a;
        u_bus.writedata = d;
        @(posedge clk);
        #1;
        u_bus.memwrite = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        u_bus.memwrite = 1'b0;
        u_bus.addr     = a;
        #1;
        chk(tag, u_bus.rdata, exp);
    endtask

    // Receiver sampling mid-bit; ok=0 if no start bit within max_cyc
    task automatic uart_rx(input int bitlen, input int max_cyc, output logic [7:0] b, output logic ok);
        int c;
        ok = 1'b0;
        b  = 8'd0;
        c  = 0;
        while (txd !== 1'b0 && c < max_cyc) begin
            step();
            c++;
        end
        if (c >= max_cyc) return;
        repeat (bitlen / 2) step();
        for (int i = 0; i < 8; i++) begin
            repeat (bitlen) step();
            b[i] = txd;
        end
        repeat (bitlen) step();
        ok = (txd === 1'b1);
    endtask

    initial begin
        logic [19:0] exp_seq;
        logic [19:0] got_seq;
        logic [9:0]  f55;
        logic [7:0]  rb;
        logic        ok;
        logic        stayed_high;

        u_bus.memwrite  = 1'b0;
        u_bus.addr      = 32'd0;
        u_bus.writedata = 32'd0;
        reset = 1'b0;

        // Reset with random bus activity
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            u_bus.memwrite  = 1'($urandom_range(0, 1));
            u_bus.addr      = BASE + 32'($urandom_range(0, 15));
            u_bus.writedata = $urandom;
            #1;
            chk("rst_txd", 32'(txd), 32'd1);
        end
        rd_chk("rst_status", A_ST, 32'h04);
        rd_chk("rst_div", A_DV, 32'd433);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) step();
        chk("rel_txd", 32'(txd), 32'd1);
        rd_chk("rel_status", A_ST, 32'h04);

        // Single frame 0x55 at DIVISOR=3
        wr(A_DV, 32'd3);
        rd_chk("div3", A_DV, 32'd3);
        wr(A_TX, 32'h55);
        u_bus.addr = A_ST;
        f55 = {1'b1, 8'h55, 1'b0};
        for (int k = 1; k <= 41; k++) begin
            step();
            if (k <= 40) begin
                chk($sformatf("f55_txd_%0d", k), 32'(txd), 32'(f55[(k - 1) / 4]));
                chk($sformatf("f55_busy_%0d", k), 32'(u_bus.rdata[0]), 32'd1);
            end else begin
                chk("f55_txd_end", 32'(txd), 32'd1);
                chk("f55_busy_end", 32'(u_bus.rdata[0]), 32'd0);
            end
        end

        // Back-to-back frames at DIVISOR=0
        wr(A_DV, 32'd0);
        @(negedge clk);
        u_bus.memwrite  = 1'b1;
        u_bus.addr      = A_TX;
        u_bus.writedata = 32'hA5;
        step();
        u_bus.writedata = 32'h3C;
        step();
        u_bus.memwrite = 1'b0;
        u_bus.addr     = A_ST;
        exp_seq = {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 20; i++) begin
            if (i > 0) step();
            got_seq[i] = txd;
            chk($sformatf("b2b_txd_%0d", i), 32'(txd), 32'(exp_seq[i]));
        end
        chk("b2b_byte0", 32'(got_seq[8:1]), 32'hA5);
        chk("b2b_byte1", 32'(got_seq[18:11]), 32'h3C);
        step();
        chk("b2b_idle_busy", 32'(u_bus.rdata[0]), 32'd0);
        chk("b2b_idle_txd", 32'(txd), 32'd1);

        // Overflow: six pushes, one popped, four buffered, one dropped
        wr(A_DV, 32'd100);
        @(negedge clk);
        u_bus.memwrite = 1'b1;
        u_bus.addr     = A_TX;
        for (int i = 0; i < 6; i++) begin
            u_bus.writedata = 32'h11 + 32'(i);
            step();
        end
        u_bus.memwrite = 1'b0;
        rd_chk("ovf_status", A_ST, 32'h4B);
        wr(A_ST, 32'h8);
        rd_chk("ovf_cleared", A_ST, 32'h43);
        for (int f = 0; f < 5; f++) begin
            uart_rx(101, 3000, rb, ok);
            chk($sformatf("ovf_frame_ok_%0d", f), 32'(ok), 32'd1);
            chk($sformatf("ovf_frame_byte_%0d", f), 32'(rb), 32'h11 + 32'(f));
        end
        uart_rx(101, 1500, rb, ok);
        chk("ovf_no_sixth", 32'(ok), 32'd0);
        rd_chk("ovf_final_status", A_ST, 32'h04);

        // Address decode
        @(negedge clk);
        u_bus.addr = BASE + 32'h10;
        #1;
        chk("dec_sel_out", 32'(u_bus.sel), 32'd0);
        chk("dec_rdata_out", u_bus.rdata, 32'd0);
        wr(BASE + 32'h10, 32'hFF);
        wr(BASE + 32'hC, 32'hFF);
        rd_chk("dec_rsvd", BASE + 32'hC, 32'd0);
        rd_chk("dec_tx_reads0", A_TX, 32'd0);
        repeat (5) step();
        chk("dec_txd", 32'(txd), 32'd1);
        rd_chk("dec_status", A_ST, 32'h04);
        rd_chk("dec_div", A_DV, 32'd100);

        // Async reset during DATA bit 3
        wr(A_DV, 32'd3);
        wr(A_TX, 32'hF7);
        wr(A_TX, 32'h0F);
        u_bus.addr = A_ST;
        repeat (17) step();
        chk("ar_bit3_low", 32'(txd), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_txd_now", 32'(txd), 32'd1);
        chk("ar_status", u_bus.rdata, 32'h04);
        @(negedge clk);
        reset = 1'b1;
        stayed_high = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (txd !== 1'b1) stayed_high = 1'b0;
        end
        chk("ar_no_residual", 32'(stayed_high), 32'd1);
        rd_chk("ar_div_reset", A_DV, 32'd433);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the single-cycle core's data-memory port, downstream of the processor. It consumes memwrite/aluout/writedata and returns read data that the top level muxes into readdata when the block is selected. Bytes written by software are buffered in a small FIFO and serialised as 8N1 frames on txd. Reads are combinational so the core never stalls.

Parameters:
BASE_ADDR, 32'h0000_FF00, 16-byte-aligned base of the register window; bits [3:0] ignored.
DEPTH, 4, TX FIFO entries; power of two, at least 2.
DIV_RESET, 16'd433, reset value of DIVISOR (clocks per bit minus 1).

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
memwrite  input  1  core store strobe.
addr  input  32  core aluout (byte address).
writedata  input  32  core store data.
sel  output  1  addr[31:4] == BASE_ADDR[31:4]; combinational.
rdata  output  32  register read data; combinational from addr and state.
txd  output  1  serial output, registered, idles high.

Behaviour:
- Register map (offset = addr[3:0], word-aligned; addr[1:0] ignored):
  - 0x0 TXDATA: write pushes writedata[7:0]; reads 0.
  - 0x4 STATUS: read {24'b0, count[3:0], ovf, empty, full, busy} (bits 7:4 count, 3 ovf, 2 empty, 1 full, 0 busy). Write with writedata[3]=1 clears ovf; other bits are ignored.
  - 0x8 DIVISOR: read/write bits [15:0]; upper bits read 0.
  - 0xC: reads 0, writes ignored.
- A write takes effect on the edge where memwrite & sel are high. rdata is valid whenever sel=1; it is 0 when sel=0.
- Reset (reset=0, asynchronous):
  - txd=1, FSM IDLE, FIFO empty (count 0), ovf=0, DIVISOR=DIV_RESET, bit timer 0.
  - Reset mid-frame aborts the frame immediately with txd=1.
- FIFO:
  - Circular buffer with wrapping read/write pointers and count 0..DEPTH.
  - full = (count==DEPTH); empty = (count==0).
  - A push while full, judged on pre-edge count, is dropped and sets ovf (sticky). This holds even if a pop occurs on the same edge.
  - A simultaneous accepted push and pop leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO not empty, pop into shift register, load timer with DIVISOR, go to START, txd<=0.
  - START/DATA/STOP: the timer decrements each cycle. When the timer reaches 0 at the end of a bit, reload it from the current DIVISOR and advance to the next bit.
  - START -> DATA sends bit0. DATA sends 8 bits LSB first using a 3-bit index; after bit7 go to STOP with txd<=1.
  - STOP end: if FIFO not empty, pop and go directly to START (txd<=0, no idle gap); else go to IDLE.
- Timing:
  - Each bit lasts DIVISOR+1 cycles; a frame lasts 10*(DIVISOR+1) cycles.
  - A TXDATA write at edge N into an empty FIFO with FSM IDLE gives txd low from edge N+1.
  - busy = (state != IDLE).
- DIVISOR writes mid-frame apply from the next bit boundary. DIVISOR=0 is legal and gives 1 cycle per bit.
- A STATUS read in the same cycle as a push reflects pre-edge state.

Test Plan:
- Reset: hold reset=0 with random inputs -> txd=1, STATUS reads 0x04, DIVISOR reads 433. Release reset -> txd stays 1 and busy=0.
- Single frame: write DIVISOR=3, then TXDATA=0x55 at edge N -> txd=0 for cycles N+1..N+4, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then stop=1 for 4 cycles. busy=0 at N+41 (frame is 40 cycles).
- Back-to-back: DIVISOR=0, write 0xA5 then 0x3C on consecutive cycles -> 20 contiguous frame cycles with no idle gap (stop of frame 1 followed directly by start of frame 2). Decoded bytes are 0xA5, 0x3C.
- Overflow: DIVISOR=100, write 6 bytes back-to-back -> first byte popped, next 4 fill the FIFO (full=1, count=4), 6th is dropped and ovf=1. Write STATUS 0x8 -> ovf=0. Only 5 frames appear on txd.
- Address decode: write 0xFF to BASE+0x10 and to BASE+0xC -> sel=0 (first case) or no effect (second); no frame starts. Read BASE+0xC returns 0; read with sel=0 returns rdata=0.
- Async reset mid-frame: assert reset=0 during DATA bit 3 between clock edges -> txd=1 immediately and FIFO empty. After release, no residual frame is sent.
